// File: rtl/launch_countdown.sv
// Launch countdown sequencer driven by a 1 Hz tick.
// Counts START_SECS down to zero, supports hold and abort, then asserts launch for
// LAUNCH_SECS ticks and pulses done on return to idle. All outputs are registered.
// Optional feature: define LAUNCH_COUNTDOWN_WARN_EN to add the final-seconds warn output.
module launch_countdown #(
  parameter int unsigned START_SECS  = 10,
  parameter int unsigned LAUNCH_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  output logic [6:0] secs_left,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [2:0] state,
`ifdef LAUNCH_COUNTDOWN_WARN_EN
  output logic       warn,
`endif
  output logic       launch,
  output logic       done
);

  localparam logic [6:0] StartVal  = 7'(START_SECS);
  localparam logic [3:0] LaunchVal = 4'(LAUNCH_SECS);
  localparam logic [3:0] StartTens = 4'(START_SECS / 10);
  localparam logic [3:0] StartOnes = 4'(START_SECS % 10);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCount   = 3'd1,
    StHold    = 3'd2,
    StLaunch  = 3'd3,
    StAborted = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] secs_q, secs_d;
  logic [3:0] lcnt_q, lcnt_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       launch_q, done_q, done_d;

  // Next-state, seconds and launch-counter logic; abort > start > hold > tick.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    lcnt_d  = lcnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        secs_d = StartVal;
        if (start) state_d = StCount;
      end
      StCount: begin
        if (abort) begin
          state_d = StAborted;
        end else if (hold) begin
          state_d = StHold;
        end else if (tick_1hz) begin
          if (secs_q <= 7'd1) begin
            secs_d  = '0;
            lcnt_d  = '0;
            state_d = StLaunch;
          end else begin
            secs_d = secs_q - 7'd1;
          end
        end
      end
      StHold: begin
        if (abort) begin
          state_d = StAborted;
        end else if (!hold) begin
          state_d = StCount;
        end
      end
      StLaunch: begin
        secs_d = '0;
        if (tick_1hz) begin
          lcnt_d = lcnt_q + 4'd1;
          if (lcnt_d == LaunchVal) begin
            state_d = StIdle;
            secs_d  = StartVal;
            lcnt_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      StAborted: begin
        if (start) begin
          state_d = StIdle;
          secs_d  = StartVal;
        end
      end
      default: begin
        state_d = StIdle;
        secs_d  = StartVal;
        lcnt_d  = '0;
      end
    endcase
  end

  // BCD digits are derived from the next seconds value so they register alongside it.
  always_comb begin
    tens_d = 4'(secs_d / 7'd10);
    ones_d = 4'(secs_d % 7'd10);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      secs_q   <= StartVal;
      lcnt_q   <= '0;
      tens_q   <= StartTens;
      ones_q   <= StartOnes;
      launch_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      secs_q   <= secs_d;
      lcnt_q   <= lcnt_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      launch_q <= (state_d == StLaunch);
      done_q   <= done_d;
    end
  end

`ifdef LAUNCH_COUNTDOWN_WARN_EN
  logic warn_q;

  // Warning tracks the registered state/seconds pair, so it drops on the edge into LAUNCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= ((state_d == StCount) || (state_d == StHold)) && (secs_d <= 7'd3);
    end
  end

  assign warn = warn_q;
`endif

  assign secs_left = secs_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign state     = state_q;
  assign launch    = launch_q;
  assign done      = done_q;

endmodule

// File: tb/tb_launch_countdown.sv
// Self-checking bench for launch_countdown: directed sequences plus random stimulus,
// every cycle compared against a behavioural model of the countdown rules.
module tb_launch_countdown;

  localparam int S = 10;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, start, hold, abort;
  logic [6:0] secs_left;
  logic [3:0] bcd_tens, bcd_ones;
  logic [2:0] state;
  logic       launch, done;
`ifdef LAUNCH_COUNTDOWN_WARN_EN
  logic       warn;
`endif

  launch_countdown #(
    .START_SECS (S),
    .LAUNCH_SECS(L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .start    (start),
    .hold     (hold),
    .abort    (abort),
    .secs_left(secs_left),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .state    (state),
`ifdef LAUNCH_COUNTDOWN_WARN_EN
    .warn     (warn),
`endif
    .launch   (launch),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // Model: mode 0 idle, 1 counting, 2 held, 3 launching, 4 aborted.
  int m_mode = 0;
  int m_secs = S;
  int m_ticks = 0;
  int m_done = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit s, input bit h, input bit a);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_secs = S; m_ticks = 0;
    end else if (m_mode == 0) begin
      m_secs = S;
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (a) m_mode = 4;
      else if (h) m_mode = 2;
      else if (t) begin
        m_secs = (m_secs > 0) ? m_secs - 1 : 0;
        if (m_secs == 0) begin m_mode = 3; m_ticks = 0; end
      end
    end else if (m_mode == 2) begin
      if (a) m_mode = 4;
      else if (!h) m_mode = 1;
    end else if (m_mode == 3) begin
      if (t) begin
        m_ticks++;
        if (m_ticks == L) begin m_mode = 0; m_secs = S; m_done = 1; end
      end
    end else begin
      if (s) begin m_mode = 0; m_secs = S; end
    end
  endtask

  task automatic compare_all();
    check("state", int'(state), m_mode);
    check("secs_left", int'(secs_left), m_secs);
    check("bcd_tens", int'(bcd_tens), m_secs / 10);
    check("bcd_ones", int'(bcd_ones), m_secs % 10);
    check("launch", int'(launch), (m_mode == 3) ? 1 : 0);
    check("done", int'(done), m_done);
`ifdef LAUNCH_COUNTDOWN_WARN_EN
    check("warn", int'(warn), ((m_mode == 1 || m_mode == 2) && m_secs <= 3) ? 1 : 0);
`endif
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, sample 1 ns later.
  task automatic cyc(input bit r, input bit t, input bit s, input bit h, input bit a);
    @(negedge clk);
    rst = r; tick_1hz = t; start = s; hold = h; abort = a;
    @(posedge clk);
    model_step(r, t, s, h, a);
    #1;
    if (done) done_seen++;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    cyc(1, 0, 0, 0, 0);
    check("reset_state", int'(state), 0);
    check("reset_secs", int'(secs_left), S);

    // Full countdown to launch and back to idle.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("start_no_dec", int'(secs_left), S);
    cyc(0, 1, 0, 0, 0);
    check("first_tick_tens", int'(bcd_tens), 0);
    check("first_tick_ones", int'(bcd_ones), 9);
    for (int i = 0; i < S - 1; i++) cyc(0, 1, 0, 0, 0);
    check("launch_entry", int'(launch), 1);
    done_seen = 0;
    for (int i = 0; i < L; i++) cyc(0, 1, 0, 0, 1);
    check("done_once", done_seen, 1);
    check("back_idle_secs", int'(secs_left), S);
    cyc(0, 0, 0, 0, 0);
    check("done_cleared", int'(done), 0);

    // Hold for several ticks, then resume.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
    check("hold_frozen", int'(secs_left), 6);
    check("hold_state", int'(state), 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("resume_dec", int'(secs_left), 5);
    cyc(0, 1, 0, 1, 0);
    check("tick_with_hold", int'(secs_left), 5);

    // Abort coincident with a tick, then acknowledge.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    check("abort_state", int'(state), 4);
    check("abort_secs", int'(secs_left), 3);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("abort_ack", int'(secs_left), S);

    // Reset mid-count.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_secs", int'(secs_left), S);

    // Random stimulus with dense ticks and level hold.
    begin
      bit h = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 9) == 0) h = ~h;
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, h, $urandom_range(0, 39) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
